// File: rtl/nanocore_lsu_if.sv
// nanocore_lsu_if: data-memory bus between the LSU and the memory port.
//   master (LSU) : drives o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wstrb
//                  samples i_mem_ready, i_mem_rdata
//   slave (mem)  : the mirror image
// Member names keep the LSU-side direction prefixes so the bus reads the
// same at both ends.
interface nanocore_lsu_if;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    input  i_mem_ready, i_mem_rdata
  );

  modport slave (
    input  o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    output i_mem_ready, i_mem_rdata
  );
endinterface

// File: rtl/nanocore_lsu.sv
// nanocore_lsu: load/store execution stage of NanoCore-two-issue.
// Takes one lsu_ctl_t op, performs one data-memory access, aligns and
// extends load data and hands it to writeback; stores report a done pulse.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_op_valid/i_op       op offered (lsu_ctl_t, 87 bits)
//   o_op_ready            op accepted when i_op_valid & o_op_ready
//   i_kill                flush: discard result of the in-flight op
//   mem                   data-memory bus (nanocore_lsu_if.master)
//   o_wb_valid/o_wb       load result (wb_entry_t, 46 bits), i_wb_ready accepts
//   o_st_done/o_st_uid    one-cycle pulse + uid for a completed store
//   o_misalign            one-cycle pulse: misaligned op rejected
//   o_busy                state != IDLE
//   o_timeout             one-cycle pulse: memory wait aborted (option only)
//
// Build option NANOCORE_LSU_TIMEOUT_EN: adds parameter TIMEOUT_CYCLES and
// port o_timeout; a MEM wait longer than TIMEOUT_CYCLES is abandoned.
//
// state | meaning
// IDLE  | ready for a new op
// MEM   | request on the bus, waiting for i_mem_ready
// WB    | load result offered to writeback
module nanocore_lsu
`ifdef NANOCORE_LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 256)
`endif
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_op_valid,
  input  logic [86:0]          i_op,
  output logic                 o_op_ready,
  input  logic                 i_kill,
  nanocore_lsu_if.master       mem,
  output logic                 o_wb_valid,
  output logic [45:0]          o_wb,
  input  logic                 i_wb_ready,
  output logic                 o_st_done,
  output logic [7:0]           o_st_uid,
  output logic                 o_misalign,
`ifdef NANOCORE_LSU_TIMEOUT_EN
  output logic                 o_timeout,
`endif
  output logic                 o_busy
);

  // mem_wordsize: 0 = byte, 1 = half, 2/3 = word
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  mem_wordsize;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        is_lu;
    logic        is_lh;
    logic        is_lb;
    logic [4:0]  rf_dst;
    logic [7:0]  uid;
  } lsu_ctl_t;

  typedef struct packed {
    logic        ready;
    logic [7:0]  uid;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t      state_q, state_d;
  lsu_ctl_t    op_q, op_d, op_in;
  logic [31:0] res_q, res_d;
  logic        kill_q, kill_d;
  logic        st_done_q, st_done_d;
  logic        misalign_q, misalign_d;
  logic [31:0] shifted;
  logic [31:0] load_res;
`ifdef NANOCORE_LSU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  assign op_in = i_op;

  function automatic logic misaligned(lsu_ctl_t op);
    case (op.mem_wordsize)
      2'b00:   return 1'b0;
      2'b01:   return op.addr[0];
      default: return |op.addr[1:0];
    endcase
  endfunction

  // Alignment: shifting by 8*addr[1:0] puts the addressed byte/half at bit 0
  // (aligned halves only occur at addr[1:0] = 0 or 2).
  always_comb begin
    shifted  = mem.i_mem_rdata >> {op_q.addr[1:0], 3'b000};
    load_res = mem.i_mem_rdata;
    if (op_q.is_lb)
      load_res = op_q.is_lu ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (op_q.is_lh)
      load_res = op_q.is_lu ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    res_d      = res_q;
    kill_d     = kill_q;
    st_done_d  = 1'b0;
    misalign_d = 1'b0;
`ifdef NANOCORE_LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (i_op_valid && !i_kill) begin
          op_d = op_in;
          if (misaligned(op_in)) begin
            misalign_d = 1'b1;
          end else begin
            state_d = MEM;
`ifdef NANOCORE_LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      MEM: begin
        // A kill does not retract the request; it only discards the outcome.
        if (i_kill) kill_d = 1'b1;
        if (mem.i_mem_ready) begin
          if (kill_q || i_kill) begin
            state_d = IDLE;
          end else if (op_q.we) begin
            st_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            res_d   = load_res;
            state_d = WB;
          end
        end
`ifdef NANOCORE_LSU_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      WB: begin
        // Kill takes priority over a simultaneous writeback handshake.
        if (i_kill || i_wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      res_q      <= '0;
      kill_q     <= 1'b0;
      st_done_q  <= 1'b0;
      misalign_q <= 1'b0;
`ifdef NANOCORE_LSU_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      res_q      <= res_d;
      kill_q     <= kill_d;
      st_done_q  <= st_done_d;
      misalign_q <= misalign_d;
`ifdef NANOCORE_LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  wb_entry_t wb_out;

  always_comb begin
    wb_out          = '0;
    if (state_q == WB) begin
      wb_out.ready    = 1'b1;
      wb_out.uid      = op_q.uid;
      wb_out.rf_dst   = op_q.rf_dst;
      wb_out.rf_wdata = res_q;
    end
  end

  assign o_op_ready      = (state_q == IDLE);
  assign o_busy          = (state_q != IDLE);
  assign mem.o_mem_valid = (state_q == MEM);
  assign mem.o_mem_addr  = (state_q == MEM) ? {op_q.addr[31:2], 2'b00} : '0;
  assign mem.o_mem_wdata = (state_q == MEM) ? op_q.wdata : '0;
  assign mem.o_mem_wstrb = (state_q == MEM && op_q.we) ? op_q.wstrb : '0;
  assign o_wb_valid      = (state_q == WB);
  assign o_wb            = wb_out;
  assign o_st_done       = st_done_q;
  assign o_st_uid        = st_done_q ? op_q.uid : '0;
  assign o_misalign      = misalign_q;
`ifdef NANOCORE_LSU_TIMEOUT_EN
  assign o_timeout       = timeout_q;
`endif

endmodule

// File: doc/nanocore_lsu.md
Name: nanocore_lsu

Overview:
Load/store execution stage for NanoCore-two-issue.
- Consumes one lsu_ctl_t op from issue, performs a single data-memory access and aligns/extends load data.
- Returns load results as a wb_entry_t to the writeback arbiter.
- Stores complete without writeback; they are reported via a done pulse carrying uid.

Parameters:
TIMEOUT_CYCLES, 256, max cycles waiting for i_mem_ready before abort (only with NANOCORE_LSU_TIMEOUT_EN)

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  reset; synchronous, active-low
i_op_valid  in  1  lsu_ctl_t op offered
i_op  in  87  lsu_ctl_t {addr,mem_wordsize,wdata,wstrb,we,is_lu,is_lh,is_lb,rf_dst,uid}
o_op_ready  out  1  op accepted when i_op_valid & o_op_ready
i_kill  in  1  flush: discard in-flight op result
o_mem_valid  out  1  memory request
o_mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
o_mem_wdata  out  32  store data
o_mem_wstrb  out  4  byte enables; 0 = read
i_mem_ready  in  1  request accepted; for reads i_mem_rdata valid same cycle
i_mem_rdata  in  32  read data
o_wb_valid  out  1  load result valid
o_wb  out  46  wb_entry_t {ready=1,uid,rf_dst,rf_wdata}
i_wb_ready  in  1  writeback accepts o_wb
o_st_done  out  1  one-cycle pulse: store completed
o_st_uid  out  8  uid of completed store
o_misalign  out  1  one-cycle pulse: misaligned op rejected
o_busy  out  1  state != IDLE

Behaviour:
- Reset (i_rst_n=0 at posedge): state IDLE; all outputs 0 except o_op_ready=1. Reset mid-access abandons op; no pulses.
- FSM IDLE -> MEM -> (WB | IDLE) -> IDLE. One op in flight; o_op_ready=1 only in IDLE.
- IDLE, accept: latch op. Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no memory access; o_misalign pulses next cycle; stay IDLE. Otherwise go MEM.
- MEM: o_mem_valid=1; addr/wdata/wstrb held stable until i_mem_ready. wstrb = op.wstrb if we else 4'b0.
  - Store + i_mem_ready: o_st_done/o_st_uid pulse next cycle; -> IDLE.
  - Load + i_mem_ready: capture aligned result; -> WB.
- Load alignment by addr[1:0]:
  - byte = rdata[8*addr+:8]; half = rdata[16*addr[1]+:16]; word = rdata.
  - Sign-extend unless is_lu; is_lb/is_lh select size, neither = word.
- WB: o_wb_valid=1, o_wb stable until i_wb_ready; on handshake -> IDLE. Earliest next op accepted the cycle after handshake.
- Load latency: accept to o_wb_valid = 2 cycles with i_mem_ready asserted in the first MEM cycle.
- i_kill:
  - In IDLE: suppresses the accept that cycle.
  - In MEM: request is NOT retracted; after i_mem_ready, go IDLE with no wb and no st_done (store still performed).
  - In WB: drop o_wb_valid next cycle; -> IDLE.
  - i_kill with i_wb_ready in WB: kill wins; no writeback counted.
- rf_dst=0 loads still perform the access and produce wb; writeback ignores x0.

Optional Feature:
NANOCORE_LSU_TIMEOUT_EN
- Defined: 16-bit counter clears on MEM entry and increments each MEM cycle without i_mem_ready. On reaching TIMEOUT_CYCLES: drop o_mem_valid, pulse o_timeout (extra 1-bit out port), -> IDLE, no wb.
- Undefined: no counter, no o_timeout port; MEM waits indefinitely.

Test Plan:
- LB addr=0x1003, rdata=0x80AABBCC, is_lb, !is_lu -> one mem read at 0x1000; o_wb.rf_wdata=0xFFFFFF80, valid 2 cycles after accept.
- LHU addr=0x2002, rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF; LW addr=0x2001 -> o_misalign pulse, no o_mem_valid.
- SW addr=0x3000, wdata=0xDEADBEEF, wstrb=4'hF, uid=0x15, i_mem_ready delayed 3 cycles -> address/data stable 4 cycles; o_st_done with o_st_uid=0x15, no o_wb_valid.
- Load result, i_wb_ready low 5 cycles -> o_wb stable, o_op_ready=0 throughout; accept next op cycle after handshake.
- i_kill in MEM while i_mem_ready low, then ready -> request completes, no wb, back to IDLE. i_kill in WB -> o_wb_valid drops next cycle.
- NANOCORE_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, i_mem_ready stuck 0 -> o_timeout after 8 MEM cycles; o_op_ready=1 next cycle.
